// File: rtl/dbg_sb_master_if.sv
// Bundles the debug SBA request port and the shared memory request/response
// bus seen by dbg_sb_master. The master modport is the sequencer's view; the
// slave modport is the view of whatever sits on the other side of both
// ports (CSR block plus interconnect, or a testbench).
interface dbg_sb_master_if;
  // Debug CSR SBA port
  logic        sb_iRead;
  logic        sb_iWrite;
  logic [31:0] sb_iAddr;
  logic [31:0] sb_iData;
  logic [2:0]  sb_iWidth;
  logic        sb_oBusy;
  logic [2:0]  sb_oErr;
  logic [31:0] sb_oData;
  logic        sb_oDone;
  // Memory request/response bus
  logic        mem_oReq;
  logic        mem_iGnt;
  logic        mem_oWe;
  logic [31:0] mem_oAddr;
  logic [3:0]  mem_oBe;
  logic [31:0] mem_oWData;
  logic        mem_iRValid;
  logic [31:0] mem_iRData;
  logic        mem_iErr;

  modport master (
    input  sb_iRead, sb_iWrite, sb_iAddr, sb_iData, sb_iWidth,
    input  mem_iGnt, mem_iRValid, mem_iRData, mem_iErr,
    output sb_oBusy, sb_oErr, sb_oData, sb_oDone,
    output mem_oReq, mem_oWe, mem_oAddr, mem_oBe, mem_oWData
  );

  modport slave (
    output sb_iRead, sb_iWrite, sb_iAddr, sb_iData, sb_iWidth,
    output mem_iGnt, mem_iRValid, mem_iRData, mem_iErr,
    input  sb_oBusy, sb_oErr, sb_oData, sb_oDone,
    input  mem_oReq, mem_oWe, mem_oAddr, mem_oBe, mem_oWData
  );
endinterface

// File: rtl/dbg_sb_master.sv
// Debug System Bus Access master: checks each SBA request for size and
// alignment, lane-steers it onto the 32-bit memory bus, waits for the
// response under a timeout and reports the outcome as a debug::sberr_e code.
package debug;
  typedef enum logic [2:0] {
    SBA_BYTE  = 3'd0,
    SBA_HALF  = 3'd1,
    SBA_WORD  = 3'd2,
    SBA_DWORD = 3'd3,
    SBA_QWORD = 3'd4
  } sbaccess_e;

  typedef enum logic [2:0] {
    SBERR_NONE        = 3'd0,
    SBERR_TIMEOUT     = 3'd1,
    SBERR_BADADDR     = 3'd2,
    SBERR_ALIGNMENT   = 3'd3,
    SBERR_UNSUPPORTED = 3'd4,
    SBERR_OTHER       = 3'd7
  } sberr_e;
endpackage

module dbg_sb_master
  import debug::*;
#(
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic             iClk,
  input logic             iRst_n,
  dbg_sb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e             state_r;
  logic               busy_r;
  logic               done_r;
  sberr_e             err_r;
  logic [31:0]        rdData_r;
  logic               memReq_r;
  logic               memWe_r;
  logic [31:0]        memAddr_r;
  logic [3:0]         memBe_r;
  logic [31:0]        memWData_r;
  logic               isRead_r;
  logic [1:0]         addrLo_r;
  logic [2:0]         width_r;
  logic [CNT_W-1:0]   timeoutCnt_r;

  logic               reqValid_s;
  sberr_e             checkErr_s;
  logic [3:0]         be_s;
  logic [31:0]        wData_s;
  logic [31:0]        laneData_s;
  logic [31:0]        rdSized_s;
  logic               cntExpire_s;

  assign reqValid_s  = bus.sb_iRead | bus.sb_iWrite;
  // The counter is cleared on entry to REQ, so value TIMEOUT_CYCLES-1 marks
  // the last cycle of the allowed window.
  assign cntExpire_s = (timeoutCnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign laneData_s  = bus.mem_iRData >> {addrLo_r, 3'b000};

  // Request checks, highest priority first: direction conflict, size, alignment.
  always_comb begin
    checkErr_s = SBERR_NONE;
    if (bus.sb_iRead && bus.sb_iWrite) begin
      checkErr_s = SBERR_OTHER;
    end else if (bus.sb_iWidth > SBA_WORD) begin
      checkErr_s = SBERR_UNSUPPORTED;
    end else if (((bus.sb_iWidth == SBA_HALF) && bus.sb_iAddr[0]) ||
                 ((bus.sb_iWidth == SBA_WORD) && (bus.sb_iAddr[1:0] != 2'b00))) begin
      checkErr_s = SBERR_ALIGNMENT;
    end else begin
      checkErr_s = SBERR_NONE;
    end
  end

  // Byte enables and lane-replicated write data for the incoming request.
  always_comb begin
    be_s    = 4'b1111;
    wData_s = bus.sb_iData;
    case (bus.sb_iWidth)
      SBA_BYTE: begin
        be_s    = 4'b0001 << bus.sb_iAddr[1:0];
        wData_s = {4{bus.sb_iData[7:0]}};
      end
      SBA_HALF: begin
        be_s    = 4'b0011 << bus.sb_iAddr[1:0];
        wData_s = {2{bus.sb_iData[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wData_s = bus.sb_iData;
      end
    endcase
  end

  // Right-justified read data masked to the registered access size.
  always_comb begin
    rdSized_s = laneData_s;
    case (width_r)
      SBA_BYTE: rdSized_s = {24'h000000, laneData_s[7:0]};
      SBA_HALF: rdSized_s = {16'h0000, laneData_s[15:0]};
      default:  rdSized_s = laneData_s;
    endcase
  end

  // Transaction sequencer: accept/check, bus request, response wait, report.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= SBERR_NONE;
      rdData_r     <= 32'h0000_0000;
      memReq_r     <= 1'b0;
      memWe_r      <= 1'b0;
      memAddr_r    <= 32'h0000_0000;
      memBe_r      <= 4'b0000;
      memWData_r   <= 32'h0000_0000;
      isRead_r     <= 1'b0;
      addrLo_r     <= 2'b00;
      width_r      <= 3'd0;
      timeoutCnt_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (reqValid_s) begin
            isRead_r <= bus.sb_iRead;
            addrLo_r <= bus.sb_iAddr[1:0];
            width_r  <= bus.sb_iWidth;
            busy_r   <= 1'b1;
            if (checkErr_s != SBERR_NONE) begin
              err_r   <= checkErr_s;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              memReq_r     <= 1'b1;
              memWe_r      <= bus.sb_iWrite;
              memAddr_r    <= {bus.sb_iAddr[31:2], 2'b00};
              memBe_r      <= be_s;
              memWData_r   <= wData_s;
              timeoutCnt_r <= '0;
              state_r      <= REQ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          timeoutCnt_r <= timeoutCnt_r + CNT_W'(1);
          // A response in the grant cycle is illegal and deliberately ignored.
          if (cntExpire_s) begin
            memReq_r <= 1'b0;
            err_r    <= SBERR_TIMEOUT;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else if (bus.mem_iGnt) begin
            memReq_r <= 1'b0;
            state_r  <= RESP;
          end else begin
            state_r <= REQ;
          end
        end
        RESP: begin
          timeoutCnt_r <= timeoutCnt_r + CNT_W'(1);
          // A response in the expiry cycle takes precedence over the timeout.
          if (bus.mem_iRValid) begin
            done_r  <= 1'b1;
            state_r <= DONE;
            if (bus.mem_iErr) begin
              err_r <= SBERR_BADADDR;
            end else begin
              err_r <= SBERR_NONE;
              if (isRead_r) begin
                rdData_r <= rdSized_s;
              end else begin
                rdData_r <= rdData_r;
              end
            end
          end else if (cntExpire_s) begin
            err_r   <= SBERR_TIMEOUT;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= RESP;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          memReq_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sb_oBusy   = busy_r;
  assign bus.sb_oErr    = err_r;
  assign bus.sb_oData   = rdData_r;
  assign bus.sb_oDone   = done_r;
  assign bus.mem_oReq   = memReq_r;
  assign bus.mem_oWe    = memWe_r;
  assign bus.mem_oAddr  = memAddr_r;
  assign bus.mem_oBe    = memBe_r;
  assign bus.mem_oWData = memWData_r;

endmodule

// File: tb/tb_dbg_sb_master.sv
// Self-checking bench for dbg_sb_master: directed SBA requests with a
// scripted memory responder; completion results are scoreboarded.
module tb_dbg_sb_master;
  import debug::*;

  localparam int TO = 8;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;

  dbg_sb_master_if sbIf ();

  dbg_sb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (sbIf)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [2:0]  err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  width;
    logic [2:0]  err;
  } errCase_t;

  exp_t        expQ[$];
  int          nCompared   = 0;
  int          nMismatched = 0;
  int          nDone       = 0;
  logic [31:0] expData     = 32'h0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [2:0] err, input logic [31:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Completion monitor: every sb_oDone pulse must match the oldest expectation.
  always @(negedge iClk) begin : doneMon
    exp_t e;
    if (sbIf.sb_oDone === 1'b1) begin
      nDone++;
      checkVal("done expected", 32'(expQ.size() > 0), 32'd1);
      checkVal("done busy", 32'(sbIf.sb_oBusy), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkVal("done err", 32'(sbIf.sb_oErr), 32'(e.err));
        checkVal("done data", sbIf.sb_oData, e.data);
      end
    end
  end

  task automatic idleInputs();
    sbIf.sb_iRead    = 1'b0;
    sbIf.sb_iWrite   = 1'b0;
    sbIf.sb_iAddr    = 32'h0;
    sbIf.sb_iData    = 32'h0;
    sbIf.sb_iWidth   = 3'd0;
    sbIf.mem_iGnt    = 1'b0;
    sbIf.mem_iRValid = 1'b0;
    sbIf.mem_iRData  = 32'h0;
    sbIf.mem_iErr    = 1'b0;
  endtask

  task automatic sendReq(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] w);
    sbIf.sb_iRead  = rd;
    sbIf.sb_iWrite = wr;
    sbIf.sb_iAddr  = addr;
    sbIf.sb_iData  = data;
    sbIf.sb_iWidth = w;
    @(posedge iClk); #1;
    sbIf.sb_iRead  = 1'b0;
    sbIf.sb_iWrite = 1'b0;
  endtask

  task automatic serveBus(input int gntWait, input logic [31:0] eAddr, input logic [3:0] eBe,
                          input logic [31:0] eWData, input logic eWe, input logic [31:0] rdata,
                          input logic rerr, input logic injectBusy, input string tag);
    int k;
    k = 0;
    while (sbIf.mem_oReq !== 1'b1 && k < 20) begin
      @(posedge iClk); #1;
      k++;
    end
    checkVal({tag, " req"}, 32'(sbIf.mem_oReq), 32'd1);
    checkVal({tag, " busy"}, 32'(sbIf.sb_oBusy), 32'd1);
    for (int i = 0; i <= gntWait; i++) begin
      checkVal({tag, " addr"}, sbIf.mem_oAddr, eAddr);
      checkVal({tag, " be"}, 32'(sbIf.mem_oBe), 32'(eBe));
      checkVal({tag, " we"}, 32'(sbIf.mem_oWe), 32'(eWe));
      if (eWe) begin
        checkVal({tag, " wdata"}, sbIf.mem_oWData, eWData);
      end
      if (i == gntWait) begin
        sbIf.mem_iGnt = 1'b1;
      end else if (injectBusy && i == 0) begin
        sbIf.sb_iWrite = 1'b1;
        sbIf.sb_iWidth = 3'd3;
        sbIf.sb_iAddr  = 32'hFFFF_FFF1;
      end
      @(posedge iClk); #1;
      sbIf.mem_iGnt  = 1'b0;
      sbIf.sb_iWrite = 1'b0;
    end
    checkVal({tag, " req drop"}, 32'(sbIf.mem_oReq), 32'd0);
    sbIf.mem_iRValid = 1'b1;
    sbIf.mem_iRData  = rdata;
    sbIf.mem_iErr    = rerr;
    @(posedge iClk); #1;
    sbIf.mem_iRValid = 1'b0;
    sbIf.mem_iErr    = 1'b0;
    checkVal({tag, " done"}, 32'(sbIf.sb_oDone), 32'd1);
    @(posedge iClk); #1;
    checkVal({tag, " idle"}, 32'(sbIf.sb_oBusy), 32'd0);
  endtask

  errCase_t errTab[7] = '{
    '{1'b0, 1'b1, 32'h0000_0013, 3'd1, 3'd3},  // HALF odd address
    '{1'b1, 1'b0, 32'h0000_0002, 3'd2, 3'd3},  // WORD misaligned
    '{1'b1, 1'b0, 32'h0000_0000, 3'd3, 3'd4},  // 64-bit
    '{1'b1, 1'b0, 32'h0000_0001, 3'd4, 3'd4},  // 128-bit beats alignment
    '{1'b0, 1'b1, 32'h0000_0000, 3'd7, 3'd4},  // undefined size code
    '{1'b1, 1'b1, 32'h0000_0000, 3'd2, 3'd7},  // read and write together
    '{1'b1, 1'b1, 32'h0000_0001, 3'd3, 3'd7}   // conflict beats size
  };

  initial begin
    int reqCycles;
    int doneBefore;
    idleInputs();
    iRst_n = 1'b0;
    #12;
    checkVal("rst busy", 32'(sbIf.sb_oBusy), 32'd0);
    checkVal("rst err", 32'(sbIf.sb_oErr), 32'd0);
    checkVal("rst data", sbIf.sb_oData, 32'd0);
    checkVal("rst done", 32'(sbIf.sb_oDone), 32'd0);
    checkVal("rst req", 32'(sbIf.mem_oReq), 32'd0);
    checkVal("rst we", 32'(sbIf.mem_oWe), 32'd0);
    checkVal("rst addr", sbIf.mem_oAddr, 32'd0);
    checkVal("rst be", 32'(sbIf.mem_oBe), 32'd0);
    checkVal("rst wdata", sbIf.mem_oWData, 32'd0);
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Word write with a two-cycle grant stall
    pushExp(SBERR_NONE, expData);
    sendReq(1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'd2);
    serveBus(2, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0, "wr word");

    // Byte read from the top lane, minimum latency
    expData = 32'h0000_00A1;
    pushExp(SBERR_NONE, expData);
    sendReq(1'b1, 1'b0, 32'h0000_2003, 32'h0, 3'd0);
    serveBus(0, 32'h0000_2000, 4'b1000, 32'h0, 1'b0, 32'hA1B2_C3D4, 1'b0, 1'b0, "rd byte");

    // Halfword write to the upper half
    pushExp(SBERR_NONE, expData);
    sendReq(1'b0, 1'b1, 32'h0000_0012, 32'h0000_5A5A, 3'd1);
    serveBus(0, 32'h0000_0010, 4'b1100, 32'h5A5A_5A5A, 1'b1, 32'h0, 1'b0, 1'b0, "wr half");

    // Check failures: done one cycle after the request, no bus request
    foreach (errTab[i]) begin
      pushExp(errTab[i].err, expData);
      sendReq(errTab[i].rd, errTab[i].wr, errTab[i].addr, 32'h1234_5678, errTab[i].width);
      checkVal("chk done lat", 32'(sbIf.sb_oDone), 32'd1);
      checkVal("chk no req", 32'(sbIf.mem_oReq), 32'd0);
      @(posedge iClk); #1;
      checkVal("chk idle", 32'(sbIf.sb_oBusy), 32'd0);
      checkVal("chk no req2", 32'(sbIf.mem_oReq), 32'd0);
    end

    // Timeout: never granted
    pushExp(SBERR_TIMEOUT, expData);
    sendReq(1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'd2);
    reqCycles = 0;
    while (sbIf.mem_oReq === 1'b1 && reqCycles < 30) begin
      reqCycles++;
      @(posedge iClk); #1;
    end
    checkVal("to req cycles", 32'(reqCycles), 32'(TO));
    checkVal("to done", 32'(sbIf.sb_oDone), 32'd1);
    @(posedge iClk); #1;
    doneBefore = nDone;
    sbIf.mem_iRValid = 1'b1;
    sbIf.mem_iRData  = 32'hFFFF_FFFF;
    @(posedge iClk); #1;
    sbIf.mem_iRValid = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    checkVal("late rvalid done", 32'(nDone), 32'(doneBefore));
    checkVal("late rvalid busy", 32'(sbIf.sb_oBusy), 32'd0);

    // Halfword read with a request pulse injected while busy
    expData = 32'h0000_1234;
    pushExp(SBERR_NONE, expData);
    sendReq(1'b1, 1'b0, 32'h0000_4002, 32'h0, 3'd1);
    serveBus(2, 32'h0000_4000, 4'b1100, 32'h0, 1'b0, 32'h1234_ABCD, 1'b0, 1'b1, "rd half busy");

    // Error response leaves read data unchanged
    pushExp(SBERR_BADADDR, expData);
    sendReq(1'b1, 1'b0, 32'h0000_4001, 32'h0, 3'd0);
    serveBus(1, 32'h0000_4000, 4'b0010, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "rd badaddr");

    // Asynchronous reset while waiting for the response
    sendReq(1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'd2);
    sbIf.mem_iGnt = 1'b1;
    @(posedge iClk); #1;
    sbIf.mem_iGnt = 1'b0;
    #2;
    iRst_n = 1'b0;
    #1;
    checkVal("arst busy", 32'(sbIf.sb_oBusy), 32'd0);
    checkVal("arst err", 32'(sbIf.sb_oErr), 32'd0);
    checkVal("arst data", sbIf.sb_oData, 32'd0);
    checkVal("arst req", 32'(sbIf.mem_oReq), 32'd0);
    checkVal("arst be", 32'(sbIf.mem_oBe), 32'd0);
    checkVal("arst addr", sbIf.mem_oAddr, 32'd0);
    @(posedge iClk); #1;
    iRst_n  = 1'b1;
    expData = 32'h0;
    @(posedge iClk); #1;

    // Clean transaction after reset
    pushExp(SBERR_NONE, expData);
    sendReq(1'b0, 1'b1, 32'h0000_6000, 32'h1357_9BDF, 3'd2);
    serveBus(0, 32'h0000_6000, 4'hF, 32'h1357_9BDF, 1'b1, 32'h0, 1'b0, 1'b0, "post rst");

    repeat (2) @(posedge iClk);
    #1;
    checkVal("queue empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
